// File: rtl/spi_sched_pkg.sv
// Shared types and the round-robin search helper for the SPI request scheduler.
// The arbiter and the scheduler top both import this package.
package spi_sched_pkg;

  localparam int RR_MAX   = 8;
  localparam int RR_IDX_W = 3;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_TX   = 2'b01,
    OP_RX   = 2'b10,
    OP_FDX  = 2'b11
  } spi_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP,
    ST_GAP
  } sched_state_t;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_result_t;

  // The search starts one past the last winner and wraps modulo n.
  function automatic rr_result_t rr_pick(input logic [RR_MAX-1:0]   valid,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int                  n);
    rr_result_t res;
    int         cand;
    res = '0;
    for (int k = 1; k <= RR_MAX; k++) begin
      cand = (int'(ptr) + k) % n;
      if (k <= n && !res.found && valid[cand[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/spi_req_sched_arb.sv
// Parameterised round-robin picker: combinational pick, with the pointer
// registered on accept. Usable for any shared peripheral with up to 8 clients.
module spi_rr_arb
  import spi_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic          found,
  output logic [IW-1:0] winner
);

  logic [IW-1:0] ptr_q;
  rr_result_t    pick;

  always_comb begin
    pick = rr_pick(RR_MAX'(req), RR_IDX_W'(ptr_q), N);
  end

  assign found  = pick.found;
  assign winner = IW'(pick.idx);

  // Pointer resets to the last index so the very first search begins at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= IW'(N - 1);
    end else if (accept && pick.found) begin
      ptr_q <= winner;
    end
  end

endmodule

// File: rtl/spi_req_sched.sv
// Round-robin scheduler sharing one spi_top between NUM_REQ clients, with a
// per-transaction timeout and an idle gap between transactions.
module spi_req_sched
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SPI_TRF_BIT = 8,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             rq_valid,
  output logic [NUM_REQ-1:0]             rq_ready,
  input  logic [2*NUM_REQ-1:0]           rq_op,
  input  logic [8*NUM_REQ-1:0]           rq_wait,
  input  logic [SPI_TRF_BIT*NUM_REQ-1:0] rq_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           rsp_err,
  output logic [SPI_TRF_BIT-1:0]         rsp_data,
  output logic [1:0]                     spi_req,
  output logic [7:0]                     spi_wait_duration,
  output logic [SPI_TRF_BIT-1:0]         spi_din,
  input  logic [SPI_TRF_BIT-1:0]         spi_dout,
  input  logic                           spi_done_tx,
  input  logic                           spi_done_rx,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  sched_state_t           state_q, state_d;
  spi_op_t                op_q, win_op;
  logic [7:0]             wait_q, win_wait;
  logic [SPI_TRF_BIT-1:0] data_q, win_data;
  logic [IW-1:0]          grant_q, win_idx;
  logic                   win_found, accept;
  logic                   tx_seen_q, rx_seen_q, tx_now, rx_now;
  logic                   xfer_done, timed_out;
  logic [TO_W-1:0]        to_cnt_q;
  logic [GAP_W-1:0]       gap_cnt_q;
  logic                   rsp_load, rsp_err_d, rsp_err_q;
  logic [SPI_TRF_BIT-1:0] rsp_data_d, rsp_data_q;

  assign accept = (state_q == ST_IDLE) && win_found;

  spi_rr_arb #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (rq_valid),
    .accept (accept),
    .found  (win_found),
    .winner (win_idx)
  );

  // Payload mux for the current winner, plus per-client ready/response strobes.
  always_comb begin
    win_op    = OP_NONE;
    win_wait  = '0;
    win_data  = '0;
    rq_ready  = '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_op      = spi_op_t'(rq_op[2*i +: 2]);
        win_wait    = rq_wait[8*i +: 8];
        win_data    = rq_data[SPI_TRF_BIT*i +: SPI_TRF_BIT];
        rq_ready[i] = accept;
      end
      rsp_valid[i] = (state_q == ST_RESP) && (grant_q == IW'(i));
    end
  end

  // Full-duplex needs both pulses; the sticky flags let them arrive in any order.
  assign tx_now    = tx_seen_q | spi_done_tx;
  assign rx_now    = rx_seen_q | spi_done_rx;
  assign timed_out = (to_cnt_q == TO_LAST);

  always_comb begin
    case (op_q)
      OP_TX:   xfer_done = spi_done_tx;
      OP_RX:   xfer_done = spi_done_rx;
      OP_FDX:  xfer_done = tx_now & rx_now;
      default: xfer_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rsp_load   = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_data_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          if (win_op == OP_NONE) begin
            state_d   = ST_RESP;
            rsp_load  = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // A completion landing on the final timeout cycle still counts as success.
        if (xfer_done) begin
          state_d    = ST_RESP;
          rsp_load   = 1'b1;
          rsp_data_d = (op_q == OP_TX) ? '0 : spi_dout;
        end else if (timed_out) begin
          state_d   = ST_RESP;
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_NONE;
      wait_q     <= '0;
      data_q     <= '0;
      grant_q    <= '0;
      tx_seen_q  <= 1'b0;
      rx_seen_q  <= 1'b0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        op_q      <= win_op;
        wait_q    <= win_wait;
        data_q    <= win_data;
        grant_q   <= win_idx;
        tx_seen_q <= 1'b0;
        rx_seen_q <= 1'b0;
        to_cnt_q  <= '0;
      end else if (state_q == ST_BUSY) begin
        tx_seen_q <= tx_now;
        rx_seen_q <= rx_now;
        to_cnt_q  <= to_cnt_q + 1'b1;
      end
      if (state_q == ST_GAP) begin
        gap_cnt_q <= gap_cnt_q + 1'b1;
      end else begin
        gap_cnt_q <= '0;
      end
      if (rsp_load) begin
        rsp_err_q  <= rsp_err_d;
        rsp_data_q <= rsp_data_d;
      end
    end
  end

  assign busy              = (state_q != ST_IDLE);
  assign grant_id          = grant_q;
  assign rsp_err           = rsp_err_q;
  assign rsp_data          = rsp_data_q;
  assign spi_req           = (state_q == ST_BUSY) ? op_q : OP_NONE;
  assign spi_wait_duration = (state_q == ST_BUSY) ? wait_q : '0;
  assign spi_din           = (state_q == ST_BUSY) ? data_q : '0;

endmodule

// File: tb/tb_spi_req_sched.sv
// Directed bench for spi_req_sched; the bench itself plays the part of spi_top
// by driving the done pulses and the received word.
module tb_spi_req_sched;

  localparam int NR = 4;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] rq_valid;
  logic [NR-1:0] rq_ready;
  logic [2*NR-1:0] rq_op;
  logic [8*NR-1:0] rq_wait;
  logic [W*NR-1:0] rq_data;
  logic [NR-1:0] rsp_valid;
  logic          rsp_err;
  logic [W-1:0]  rsp_data;
  logic [1:0]    spi_req;
  logic [7:0]    spi_wait_duration;
  logic [W-1:0]  spi_din;
  logic [W-1:0]  spi_dout;
  logic          spi_done_tx;
  logic          spi_done_rx;
  logic          busy;
  logic [1:0]    grant_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_req_sched #(
    .NUM_REQ     (NR),
    .SPI_TRF_BIT (W),
    .GAP_CYC     (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rq_valid          (rq_valid),
    .rq_ready          (rq_ready),
    .rq_op             (rq_op),
    .rq_wait           (rq_wait),
    .rq_data           (rq_data),
    .rsp_valid         (rsp_valid),
    .rsp_err           (rsp_err),
    .rsp_data          (rsp_data),
    .spi_req           (spi_req),
    .spi_wait_duration (spi_wait_duration),
    .spi_din           (spi_din),
    .spi_dout          (spi_dout),
    .spi_done_tx       (spi_done_tx),
    .spi_done_rx       (spi_done_rx),
    .busy              (busy),
    .grant_id          (grant_id)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [1:0] op,
                               input logic [7:0] wt, input logic [W-1:0] dt);
    rq_valid[idx]         = v;
    rq_op[2*idx +: 2]     = op;
    rq_wait[8*idx +: 8]   = wt;
    rq_data[W*idx +: W]   = dt;
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 30 && busy; i++) begin
      @(negedge clk); #1;
    end
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_order [6];
    int gap_cnt;
    int wait_cnt;
    int busy_cnt;
    logic [NR-1:0] exp_oh;

    exp_order = '{0, 1, 3, 0, 1, 3};
    rst = 1'b1;
    rq_valid = '0; rq_op = '0; rq_wait = '0; rq_data = '0;
    spi_dout = '0; spi_done_tx = 1'b0; spi_done_rx = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_spi_req", 32'(spi_req), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Single TX from requester 0
    @(negedge clk); applyStimulus(0, 1'b1, 2'b01, 8'd3, 8'hA5); #1;
    checkOutput("t1_ready", 32'(rq_ready), 32'h1);
    checkOutput("t1_req_before", 32'(spi_req), 32'd0);
    @(negedge clk); applyStimulus(0, 1'b0, 2'b00, 8'd0, 8'h00); #1;
    checkOutput("t1_spi_req", 32'(spi_req), 32'h1);
    checkOutput("t1_spi_din", 32'(spi_din), 32'hA5);
    checkOutput("t1_spi_wait", 32'(spi_wait_duration), 32'd3);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_no_ready", 32'(rq_ready), 32'd0);
    @(negedge clk); spi_done_tx = 1'b1; #1;
    checkOutput("t1_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk); spi_done_tx = 1'b0; #1;
    checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t1_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("t1_rsp_data", 32'(rsp_data), 32'h00);
    checkOutput("t1_req_drop", 32'(spi_req), 32'd0);
    waitIdle("t1_idle");

    // Full duplex from requester 2, done_rx then done_tx
    @(negedge clk); applyStimulus(2, 1'b1, 2'b11, 8'd5, 8'h3C); #1;
    checkOutput("t2_ready", 32'(rq_ready), 32'h4);
    @(negedge clk); applyStimulus(2, 1'b0, 2'b00, 8'd0, 8'h00);
    spi_dout = 8'hC3; spi_done_rx = 1'b1; #1;
    checkOutput("t2_spi_req", 32'(spi_req), 32'h3);
    checkOutput("t2_spi_din", 32'(spi_din), 32'h3C);
    @(negedge clk); spi_done_rx = 1'b0; #1;
    checkOutput("t2_no_rsp_after_rx", 32'(rsp_valid), 32'd0);
    @(negedge clk); spi_done_tx = 1'b1; #1;
    checkOutput("t2_still_busy", 32'(spi_req), 32'h3);
    @(negedge clk); spi_done_tx = 1'b0; spi_dout = 8'h00; #1;
    checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'h4);
    checkOutput("t2_rsp_data", 32'(rsp_data), 32'hC3);
    checkOutput("t2_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk); #1;
    checkOutput("t2_single_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("t2_data_hold", 32'(rsp_data), 32'hC3);
    waitIdle("t2_idle");

    // Round-robin fairness from a fresh pointer
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    applyStimulus(0, 1'b1, 2'b01, 8'd1, 8'h10);
    applyStimulus(1, 1'b1, 2'b01, 8'd1, 8'h11);
    applyStimulus(3, 1'b1, 2'b01, 8'd1, 8'h13);
    #1;
    for (int t = 0; t < 6; t++) begin
      gap_cnt = 0;
      wait_cnt = 0;
      while (rq_ready == '0 && wait_cnt < 20) begin
        @(negedge clk); #1;
        wait_cnt++;
        if (busy && spi_req == 2'b00 && rsp_valid == '0) gap_cnt++;
      end
      exp_oh = NR'(1 << exp_order[t]);
      checkOutput($sformatf("t3_ready%0d", t), 32'(rq_ready), 32'(exp_oh));
      if (t > 0) checkOutput($sformatf("t3_gap%0d", t), 32'(gap_cnt), 32'd4);
      @(negedge clk);
      if (t == 5) rq_valid = '0;
      #1;
      checkOutput($sformatf("t3_grant%0d", t), 32'(grant_id), 32'(exp_order[t]));
      checkOutput($sformatf("t3_din%0d", t), 32'(spi_din), 32'(8'h10 + 8'(exp_order[t])));
      checkOutput($sformatf("t3_req%0d", t), 32'(spi_req), 32'h1);
      spi_done_tx = 1'b1;
      @(negedge clk); spi_done_tx = 1'b0; #1;
      checkOutput($sformatf("t3_rsp%0d", t), 32'(rsp_valid), 32'(exp_oh));
    end
    waitIdle("t3_idle");

    // Timeout: full duplex sees only done_rx, then requester 2 runs normally
    @(negedge clk);
    applyStimulus(1, 1'b1, 2'b11, 8'd7, 8'h55);
    applyStimulus(2, 1'b1, 2'b10, 8'd2, 8'h66);
    #1;
    checkOutput("t4_ready", 32'(rq_ready), 32'h2);
    @(negedge clk); applyStimulus(1, 1'b0, 2'b00, 8'd0, 8'h00);
    spi_dout = 8'h77; spi_done_rx = 1'b1; #1;
    busy_cnt = 0;
    while (spi_req == 2'b11 && busy_cnt < 40) begin
      busy_cnt++;
      @(negedge clk); spi_done_rx = 1'b0; #1;
    end
    checkOutput("t4_busy_cycles", 32'(busy_cnt), 32'd16);
    checkOutput("t4_rsp_valid", 32'(rsp_valid), 32'h2);
    checkOutput("t4_rsp_err", 32'(rsp_err), 32'd1);
    checkOutput("t4_rsp_data", 32'(rsp_data), 32'h00);
    wait_cnt = 0;
    while (rq_ready == '0 && wait_cnt < 20) begin
      @(negedge clk); #1;
      wait_cnt++;
    end
    checkOutput("t4_next_ready", 32'(rq_ready), 32'h4);
    @(negedge clk); applyStimulus(2, 1'b0, 2'b00, 8'd0, 8'h00); #1;
    checkOutput("t4_next_req", 32'(spi_req), 32'h2);
    spi_dout = 8'h5A; spi_done_rx = 1'b1;
    @(negedge clk); spi_done_rx = 1'b0; #1;
    checkOutput("t4_next_rsp", 32'(rsp_valid), 32'h4);
    checkOutput("t4_next_err", 32'(rsp_err), 32'd0);
    checkOutput("t4_next_data", 32'(rsp_data), 32'h5A);
    waitIdle("t4_idle");

    // Stray done in IDLE, then an illegal op
    @(negedge clk); spi_done_rx = 1'b1; #1;
    @(negedge clk); spi_done_rx = 1'b0; #1;
    checkOutput("t5_stray_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("t5_stray_busy", 32'(busy), 32'd0);
    @(negedge clk); applyStimulus(3, 1'b1, 2'b00, 8'd9, 8'hFF); #1;
    checkOutput("t5_ready", 32'(rq_ready), 32'h8);
    @(negedge clk); applyStimulus(3, 1'b0, 2'b00, 8'd0, 8'h00); #1;
    checkOutput("t5_rsp_valid", 32'(rsp_valid), 32'h8);
    checkOutput("t5_rsp_err", 32'(rsp_err), 32'd1);
    checkOutput("t5_rsp_data", 32'(rsp_data), 32'h00);
    checkOutput("t5_spi_req", 32'(spi_req), 32'd0);
    waitIdle("t5_idle");

    // Asynchronous reset while BUSY
    @(negedge clk); applyStimulus(2, 1'b1, 2'b01, 8'd4, 8'h99); #1;
    checkOutput("t6_ready", 32'(rq_ready), 32'h4);
    @(negedge clk); applyStimulus(2, 1'b0, 2'b00, 8'd0, 8'h00); #1;
    checkOutput("t6_spi_req", 32'(spi_req), 32'h1);
    @(negedge clk); #2 rst = 1'b1; #1;
    checkOutput("t6_async_req", 32'(spi_req), 32'd0);
    checkOutput("t6_async_busy", 32'(busy), 32'd0);
    checkOutput("t6_async_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    applyStimulus(0, 1'b1, 2'b01, 8'd1, 8'h21);
    applyStimulus(3, 1'b1, 2'b01, 8'd1, 8'h24);
    #1;
    checkOutput("t6_first_grant", 32'(rq_ready), 32'h1);
    @(negedge clk); applyStimulus(0, 1'b0, 2'b00, 8'd0, 8'h00);
    applyStimulus(3, 1'b0, 2'b00, 8'd0, 8'h00); #1;
    checkOutput("t6_grant_id", 32'(grant_id), 32'd0);
    spi_done_tx = 1'b1;
    @(negedge clk); spi_done_tx = 1'b0; #1;
    checkOutput("t6_rsp_valid", 32'(rsp_valid), 32'h1);
    waitIdle("t6_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
